// File: rtl/serial_tx.sv
// serial_tx: byte-wide serial transmitter with valid/ready acceptance.
// Each frame is a start bit (0), eight data bits LSB first and a stop bit (1).
// Every bit is held for CLKS_PER_BIT clocks. txd is registered and idles high.
// Optional feature: define SERIAL_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module serial_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       valid,
  output logic       ready,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_txd;
  logic        r_done;

  state_t      w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_txd_nxt;
  logic        w_done_nxt;
  logic        w_bit_end;

  assign w_bit_end = (r_cnt == LP_LAST);

  // State, counters, latched byte and the registered line; reset abandons any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic; txd is computed one cycle ahead so the line is registered.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_bit_end ? 16'd0 : r_cnt + 16'd1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 16'd0;
        w_txd_nxt = 1'b1;
        if (valid) begin
          w_state_nxt = S_START;
          w_shift_nxt = din;
          w_txd_nxt   = 1'b0;
        end
      end
      S_START: begin
        w_txd_nxt = 1'b0;
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = 3'd0;
          w_txd_nxt   = r_shift[0];
        end
      end
      S_DATA: begin
        w_txd_nxt = r_shift[r_idx];
        if (w_bit_end) begin
          if (r_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            w_state_nxt = S_PARITY;
            w_txd_nxt   = ^r_shift;
`else
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
`endif
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_txd_nxt = r_shift[r_idx + 3'd1];
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        w_txd_nxt = ^r_shift;
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_txd_nxt   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        w_txd_nxt = 1'b1;
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = ~ready;
  assign done  = r_done;
  assign txd   = r_txd;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: randomized self-checking bench for serial_tx (CLKS_PER_BIT=4).
// The reference model describes a frame as a list of bit values and checks
// txd/ready/busy/done every cycle. Define SERIAL_TX_PARITY_EN for parity builds.
module tb_serial_tx;

  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ready;
  logic       txd;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  serial_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .valid (valid),
    .ready (ready),
    .txd   (txd),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame bit i of byte b: start, data LSB first, optional even parity, stop.
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9 && NB == 11) return ^b;
    return 1'b1;
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_txd", txd, 1);
      chk("idle_rdy", ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end
  endtask

  // mode: 0 drop valid after accept, 1 toggle valid/din each cycle, 2 hold valid high.
  // abort_at >= 0 asserts reset in that cycle of the frame and returns after release.
  task automatic run_frame(input logic [7:0] b, input int mode, input int abort_at);
    valid = 1'b1;
    din   = b;
    @(negedge clk);
    for (int k = 0; k < NB*CPB; k++) begin
      chk("txd", txd, exp_bit(b, k / CPB));
      chk("rdy_busy", ready, 0);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      if (k == abort_at) begin
        rst   = 1'b1;
        valid = 1'b0;
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_rdy", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        chk("rst_done2", done, 0);
        chk("rst_txd2", txd, 1);
        rst = 1'b0;
        return;
      end
      case (mode)
        1: begin valid = ~valid; din = 8'($urandom); end
        2: begin valid = 1'b1; din = 8'($urandom); end
        default: valid = 1'b0;
      endcase
      @(negedge clk);
    end
    chk("done", done, 1);
    chk("done_rdy", ready, 1);
    chk("done_busy", busy, 0);
    chk("done_txd", txd, 1);
    valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_rst_txd", txd, 1);
      chk("in_rst_rdy", ready, 1);
      chk("in_rst_busy", busy, 0);
      chk("in_rst_done", done, 0);
    end
    rst = 1'b0;
    idle_check(20);

    run_frame(8'hA5, 0, -1);
    idle_check(3);
    run_frame(8'h07, 0, -1);
    idle_check(2);

    run_frame(8'h00, 2, -1);
    run_frame(8'hFF, 2, -1);
    idle_check(1);

    run_frame(8'h3C, 0, 3*CPB);
    run_frame(8'h81, 0, -1);
    idle_check(2);

    run_frame(8'h5A, 1, -1);
    idle_check(1);

    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      int mode;
      int ab;
      b    = 8'($urandom);
      mode = int'($urandom_range(0, 2));
      ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NB*CPB-1)) : -1;
      run_frame(b, mode, ab);
      if ($urandom_range(0, 1) == 1) idle_check(int'($urandom_range(1, 3)));
    end
    idle_check(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
